ldi_timing_gen: RTL

LDI_TIMING_GEN -- requirements
Module: ldi_timing_gen

---
 rtl/ldi_pkg.sv | 21 ++
 rtl/ldi_timing_cnt.sv | 61 ++++++
 rtl/ldi_timing_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ldi_pkg.sv
// rtl/ldi_pkg.sv - shared types and constants for the LDI display timing generator
package ldi_pkg;

    localparam int LDI_CW        = 12;
    localparam int LDI_MAX_TOTAL = 4096;

    localparam int LDI_H_ACTIVE = 1024;
    localparam int LDI_H_FRONT  = 24;
    localparam int LDI_H_SYNC   = 136;
    localparam int LDI_H_BACK   = 160;
    localparam int LDI_V_ACTIVE = 768;
    localparam int LDI_V_FRONT  = 3;
    localparam int LDI_V_SYNC   = 6;
    localparam int LDI_V_BACK   = 29;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ldi_state_e;

endpackage

// File: rtl/ldi_timing_cnt.sv
// rtl/ldi_timing_cnt.sv - wrapping position counter with active/sync region decode of its next value
module ldi_timing_cnt
    import ldi_pkg::*;
#(
    parameter int active = 8,
    parameter int front  = 2,
    parameter int sync   = 3,
    parameter int back   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [LDI_CW-1:0] count_d_o,
    output logic              wrap_o,
    output logic              active_d_o,
    output logic              sync_d_o
);

    localparam int CW1   = LDI_CW + 1;
    localparam int TOTAL = active + front + sync + back;

    localparam logic [LDI_CW-1:0] LAST     = LDI_CW'(TOTAL - 1);
    localparam logic [CW1-1:0]    ACT_END  = CW1'(active);
    localparam logic [CW1-1:0]    SYNC_BEG = CW1'(active + front);
    localparam logic [CW1-1:0]    SYNC_END = CW1'(active + front + sync);

    if (TOTAL > LDI_MAX_TOTAL || active == 0 || sync == 0) begin : g_bad_param
        $error("ldi_timing_cnt: total above 4096 or zero-length active/sync region");
    end

    logic [LDI_CW-1:0] count_q;
    logic [LDI_CW-1:0] count_d;
    logic [CW1-1:0]    count_x;

    assign wrap_o = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (advance_i) begin
            count_d = wrap_o ? '0 : count_q + LDI_CW'(1);
        end
    end

    // Regions decode the next count so the owner can register outputs in step with it.
    assign count_x    = {1'b0, count_d};
    assign count_d_o  = count_d;
    assign active_d_o = (count_x < ACT_END);
    assign sync_d_o   = (count_x >= SYNC_BEG) && (count_x < SYNC_END);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ldi_timing_gen.sv
// rtl/ldi_timing_gen.sv - LDI panel timing generator: sync, data enable and pixel position
module ldi_timing_gen
    import ldi_pkg::*;
#(
    parameter int   h_active  = LDI_H_ACTIVE,
    parameter int   h_front   = LDI_H_FRONT,
    parameter int   h_sync    = LDI_H_SYNC,
    parameter int   h_back    = LDI_H_BACK,
    parameter int   v_active  = LDI_V_ACTIVE,
    parameter int   v_front   = LDI_V_FRONT,
    parameter int   v_sync    = LDI_V_SYNC,
    parameter int   v_back    = LDI_V_BACK,
    parameter logic hsync_pol = 1'b1,
    parameter logic vsync_pol = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              pll_locked,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [LDI_CW-1:0] x,
    output logic [LDI_CW-1:0] y,
    output logic              line_start,
    output logic              frame_start,
    output logic              running
);

    ldi_state_e state_q, state_d;

    logic lock_meta_q, lock_q;

    logic              cnt_clear;
    logic [LDI_CW-1:0] h_d, v_d;
    logic              h_wrap, v_wrap;
    logic              h_act_d, v_act_d;
    logic              h_sync_d, v_sync_d;
    logic              run_d;
    logic              de_d;

    logic              hsync_q, vsync_q, de_q, line_start_q, frame_start_q, running_q;
    logic [LDI_CW-1:0] x_q, y_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (enable && lock_q) state_d = ST_RUN;
            ST_RUN: begin
                if (!lock_q) begin
                    state_d = ST_IDLE;
                end else if (h_wrap && v_wrap && !enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters stay at zero outside RUN and on the entry cycle, so RUN always opens at 0,0.
    assign cnt_clear = (state_q != ST_RUN) || (state_d != ST_RUN);
    assign run_d     = (state_d == ST_RUN);
    assign de_d      = run_d && h_act_d && v_act_d;

    ldi_timing_cnt #(
        .active (h_active),
        .front  (h_front),
        .sync   (h_sync),
        .back   (h_back)
    ) u_h_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (cnt_clear),
        .advance_i  (1'b1),
        .count_d_o  (h_d),
        .wrap_o     (h_wrap),
        .active_d_o (h_act_d),
        .sync_d_o   (h_sync_d)
    );

    ldi_timing_cnt #(
        .active (v_active),
        .front  (v_front),
        .sync   (v_sync),
        .back   (v_back)
    ) u_v_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (cnt_clear),
        .advance_i  (h_wrap),
        .count_d_o  (v_d),
        .wrap_o     (v_wrap),
        .active_d_o (v_act_d),
        .sync_d_o   (v_sync_d)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            lock_meta_q   <= 1'b0;
            lock_q        <= 1'b0;
            hsync_q       <= ~hsync_pol;
            vsync_q       <= ~vsync_pol;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lock_meta_q   <= pll_locked;
            lock_q        <= lock_meta_q;
            hsync_q       <= (run_d && h_sync_d) ? hsync_pol : ~hsync_pol;
            vsync_q       <= (run_d && v_sync_d) ? vsync_pol : ~vsync_pol;
            de_q          <= de_d;
            x_q           <= de_d ? h_d : '0;
            y_q           <= de_d ? v_d : '0;
            line_start_q  <= run_d && (h_d == '0);
            frame_start_q <= run_d && (h_d == '0) && (v_d == '0);
            running_q     <= run_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;

endmodule
